// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: receives a sync/length/payload frame, writes it into instruction
// memory, and holds the core in reset until the image is in. Optional macro: BOOT_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         IMEM_AW      = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_reset,
  output logic               boot_done,
  output logic               boot_err
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      CAPACITY = 17'(1) << IMEM_AW;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef BOOT_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } ld_state_t;

  // ---------------------------------------------------------------- UART RX
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_frame_err;
  logic [7:0]       w_byte;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples
  // pre-edge values; the synchronizer chain depends on this to stay two flops deep.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state   <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_clk_cnt  <= '0;
          end
        end
        RX_START: begin
          // Mid start bit: a line back high means the edge was a glitch.
          if (r_clk_cnt == HALF_M1) begin
            r_clk_cnt <= '0;
            if (r_rx_sync) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_DATA;
              r_bit_idx  <= '0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt  <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // The shift register holds still until the next start bit, so it doubles as the byte output.
  assign w_byte = r_shift;

  // ---------------------------------------------------------------- Loader FSM
  ld_state_t        r_state;
  logic [15:0]      r_len;
  logic [1:0]       r_byte_idx;
  logic [IMEM_AW:0] r_word_idx;
  logic [23:0]      r_asm;
  logic             r_we;
  logic [IMEM_AW-1:0] r_waddr;
  logic [31:0]      r_wdata;
  logic             r_cpu_reset;
  logic             r_boot_done;
  logic             r_boot_err;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       r_chk;
`endif
  logic [15:0]      w_len_full;

  assign w_len_full = {w_byte, r_len[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WAIT_SYNC;
      r_len       <= '0;
      r_byte_idx  <= '0;
      r_word_idx  <= '0;
      r_asm       <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_boot_done <= 1'b0;
      r_boot_err  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_chk       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (r_frame_err && r_state != WAIT_SYNC && r_state != DONE && r_state != ERR) begin
        r_state <= ERR;
      end else begin
        case (r_state)
          WAIT_SYNC: begin
            if (r_byte_valid && w_byte == SYNC_BYTE) begin
              r_state    <= LEN_LO;
              r_byte_idx <= '0;
              r_word_idx <= '0;
`ifdef BOOT_CHECKSUM_EN
              r_chk      <= '0;
`endif
            end
          end
          LEN_LO: begin
            if (r_byte_valid) begin
              r_len[7:0] <= w_byte;
              r_state    <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (r_byte_valid) begin
              r_len[15:8] <= w_byte;
              if (w_len_full == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                r_state <= CHK;
`else
                r_state <= DONE;
`endif
              end else if (17'(w_len_full) > CAPACITY) begin
                r_state <= ERR;
              end else begin
                r_state <= DATA;
              end
            end
          end
          DATA: begin
            if (r_byte_valid) begin
`ifdef BOOT_CHECKSUM_EN
              r_chk <= r_chk ^ w_byte;
`endif
              r_byte_idx <= r_byte_idx + 1'b1;
              if (r_byte_idx == 2'd3) begin
                r_we       <= 1'b1;
                r_wdata    <= {w_byte, r_asm};
                r_waddr    <= r_word_idx[IMEM_AW-1:0];
                r_word_idx <= r_word_idx + 1'b1;
                if (16'(r_word_idx) == r_len - 16'd1) begin
`ifdef BOOT_CHECKSUM_EN
                  r_state <= CHK;
`else
                  r_state <= DONE;
`endif
                end
              end else begin
                r_asm[{r_byte_idx, 3'b000} +: 8] <= w_byte;
              end
            end
          end
`ifdef BOOT_CHECKSUM_EN
          CHK: begin
            if (r_byte_valid) begin
              r_state <= (w_byte == r_chk) ? DONE : ERR;
            end
          end
`endif
          DONE: begin
            r_cpu_reset <= 1'b0;
            r_boot_done <= 1'b1;
          end
          ERR: begin
            // Sticky until reset; the core stays held.
            r_boot_err  <= 1'b1;
            r_cpu_reset <= 1'b1;
          end
          default: r_state <= ERR;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign boot_done  = r_boot_done;
  assign boot_err   = r_boot_err;

endmodule
